// File: rtl/order_tx_serializer.sv
// order_tx_serializer
//
// Purpose: takes a buy/sell pair of 9-word quote messages, presented in
// parallel for one i_valid cycle, and serialises it as 18 words (buy words
// 0..8, then sell words 0..8) onto a 32-bit valid/ready stream. It holds one
// active pair plus one pending pair. A pair that arrives while both are
// occupied is dropped and counted, unless the active pair completes in that
// same cycle.
//
// Handshake: a word moves when o_tvalid & i_tready are both high on a rising
// edge. o_tvalid never falls without a transfer (reset excepted), and while it
// is high with i_tready low, o_tdata/o_tlast/o_tside hold their values.
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_valid                 one-cycle strobe qualifying i_reg_*_b / i_reg_*_s
//   i_reg_0_b..i_reg_8_b    buy message words 0..8
//   i_reg_0_s..i_reg_8_s    sell message words 0..8
//   o_tdata/o_tvalid/i_tready/o_tlast/o_tside   egress word stream
//                           (o_tlast marks word 8, o_tside: 0 buy, 1 sell)
//   o_pending_full          registered pending-slot occupancy
//   o_drop_count            saturating count of dropped pairs
//   o_state_dbg             current FSM state (0 idle, 1 buy, 2 sell)
//
// The input port list is fixed at nine words per side, so NUM_REGS must be 9.
module order_tx_serializer #(
  parameter int REG_WIDTH      = 32,
  parameter int NUM_REGS       = 9,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [REG_WIDTH-1:0]      i_reg_0_b,
  input  logic [REG_WIDTH-1:0]      i_reg_1_b,
  input  logic [REG_WIDTH-1:0]      i_reg_2_b,
  input  logic [REG_WIDTH-1:0]      i_reg_3_b,
  input  logic [REG_WIDTH-1:0]      i_reg_4_b,
  input  logic [REG_WIDTH-1:0]      i_reg_5_b,
  input  logic [REG_WIDTH-1:0]      i_reg_6_b,
  input  logic [REG_WIDTH-1:0]      i_reg_7_b,
  input  logic [REG_WIDTH-1:0]      i_reg_8_b,
  input  logic [REG_WIDTH-1:0]      i_reg_0_s,
  input  logic [REG_WIDTH-1:0]      i_reg_1_s,
  input  logic [REG_WIDTH-1:0]      i_reg_2_s,
  input  logic [REG_WIDTH-1:0]      i_reg_3_s,
  input  logic [REG_WIDTH-1:0]      i_reg_4_s,
  input  logic [REG_WIDTH-1:0]      i_reg_5_s,
  input  logic [REG_WIDTH-1:0]      i_reg_6_s,
  input  logic [REG_WIDTH-1:0]      i_reg_7_s,
  input  logic [REG_WIDTH-1:0]      i_reg_8_s,
  output logic [REG_WIDTH-1:0]      o_tdata,
  output logic                      o_tvalid,
  input  logic                      i_tready,
  output logic                      o_tlast,
  output logic                      o_tside,
  output logic                      o_pending_full,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_count,
  output logic [1:0]                o_state_dbg
);

  localparam int PAIR_WORDS = 2 * NUM_REGS;
  localparam int IDX_W      = $clog2(NUM_REGS);
  localparam int ADDR_W     = $clog2(PAIR_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_BUY  = 2'd1,
    SEND_SELL = 2'd2
  } state_t;

  state_t                      state, state_next;
  logic [IDX_W-1:0]            idx, idx_next;
  logic                        pend_valid, pend_valid_next;
  logic [DROP_CNT_WIDTH-1:0]   drop_cnt;

  // Pair storage: entries 0..NUM_REGS-1 are buy, NUM_REGS.. are sell.
  logic [REG_WIDTH-1:0]        in_words [PAIR_WORDS];
  logic [REG_WIDTH-1:0]        act_mem  [PAIR_WORDS];
  logic [REG_WIDTH-1:0]        pend_mem [PAIR_WORDS];

  logic                        load_act_in, load_act_pend, load_pend_in, drop;
  logic                        xfer, pair_done;
  logic [ADDR_W-1:0]           rd_addr;

  always_comb begin
    in_words[0]  = i_reg_0_b;  in_words[1]  = i_reg_1_b;  in_words[2]  = i_reg_2_b;
    in_words[3]  = i_reg_3_b;  in_words[4]  = i_reg_4_b;  in_words[5]  = i_reg_5_b;
    in_words[6]  = i_reg_6_b;  in_words[7]  = i_reg_7_b;  in_words[8]  = i_reg_8_b;
    in_words[9]  = i_reg_0_s;  in_words[10] = i_reg_1_s;  in_words[11] = i_reg_2_s;
    in_words[12] = i_reg_3_s;  in_words[13] = i_reg_4_s;  in_words[14] = i_reg_5_s;
    in_words[15] = i_reg_6_s;  in_words[16] = i_reg_7_s;  in_words[17] = i_reg_8_s;
  end

  // Outputs decode straight from registered state, so they are stable for
  // as long as the state/index registers hold (i.e. until a transfer).
  assign o_tvalid       = (state != IDLE);
  assign xfer           = o_tvalid & i_tready;
  assign pair_done      = (state == SEND_SELL) && xfer && (idx == IDX_LAST);
  assign rd_addr        = (state == SEND_SELL) ? ADDR_W'(NUM_REGS) + ADDR_W'(idx)
                                               : ADDR_W'(idx);
  assign o_tdata        = o_tvalid ? act_mem[rd_addr] : '0;
  assign o_tlast        = o_tvalid && (idx == IDX_LAST);
  assign o_tside        = (state == SEND_SELL);
  assign o_pending_full = pend_valid;
  assign o_drop_count   = drop_cnt;
  assign o_state_dbg    = state;

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    pend_valid_next = pend_valid;
    load_act_in     = 1'b0;
    load_act_pend   = 1'b0;
    load_pend_in    = 1'b0;
    drop            = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_valid) begin
          load_act_in = 1'b1;
          idx_next    = '0;
          state_next  = SEND_BUY;
        end
      end
      SEND_BUY: begin
        if (xfer) begin
          if (idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = SEND_SELL;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      SEND_SELL: begin
        if (xfer && idx != IDX_LAST) idx_next = idx + 1'b1;
      end
      default: state_next = IDLE;
    endcase

    if (pair_done) begin
      idx_next = '0;
      if (pend_valid) begin
        // Pending pair becomes active; a coincident new pair refills pending.
        load_act_pend   = 1'b1;
        state_next      = SEND_BUY;
        load_pend_in    = i_valid;
        pend_valid_next = i_valid;
      end else if (i_valid) begin
        // Bypass pending so the new pair follows without a bubble.
        load_act_in = 1'b1;
        state_next  = SEND_BUY;
      end else begin
        state_next = IDLE;
      end
    end else if (state != IDLE && i_valid) begin
      if (!pend_valid) begin
        load_pend_in    = 1'b1;
        pend_valid_next = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      idx        <= '0;
      pend_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      pend_valid <= pend_valid_next;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Data storage needs no reset: it is only observed through o_tdata, which
  // is gated by the FSM state.
  always_ff @(posedge i_clk) begin
    if (load_act_in)        act_mem <= in_words;
    else if (load_act_pend) act_mem <= pend_mem;
    if (load_pend_in)       pend_mem <= in_words;
  end

endmodule

// File: tb/tb_order_tx_serializer.sv
// Bench for order_tx_serializer. The reference model is a queue of expected
// output words {side, last, data}: each accepted pair appends 18 entries and
// each transfer pops the head. Buffer occupancy follows from the queue depth:
// more than 18 queued words means a pending pair is held.
module tb_order_tx_serializer;
  localparam int W  = 32;
  localparam int N  = 9;
  localparam int DW = 16;
  localparam int PW = 2 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          tready;
  logic [W-1:0]  buy_w  [N];
  logic [W-1:0]  sell_w [N];
  logic [W-1:0]  tdata;
  logic          tvalid, tlast, tside, pending_full;
  logic [DW-1:0] drop_count;
  logic [1:0]    state_dbg;

  logic [W+1:0]  exp_q [$];
  int            drops_exp;
  int            n_cmp;
  int            n_err;

  always #5 clk = ~clk;

  order_tx_serializer #(.REG_WIDTH(W), .NUM_REGS(N), .DROP_CNT_WIDTH(DW)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid),
    .i_reg_0_b(buy_w[0]), .i_reg_1_b(buy_w[1]), .i_reg_2_b(buy_w[2]),
    .i_reg_3_b(buy_w[3]), .i_reg_4_b(buy_w[4]), .i_reg_5_b(buy_w[5]),
    .i_reg_6_b(buy_w[6]), .i_reg_7_b(buy_w[7]), .i_reg_8_b(buy_w[8]),
    .i_reg_0_s(sell_w[0]), .i_reg_1_s(sell_w[1]), .i_reg_2_s(sell_w[2]),
    .i_reg_3_s(sell_w[3]), .i_reg_4_s(sell_w[4]), .i_reg_5_s(sell_w[5]),
    .i_reg_6_s(sell_w[6]), .i_reg_7_s(sell_w[7]), .i_reg_8_s(sell_w[8]),
    .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready), .o_tlast(tlast),
    .o_tside(tside), .o_pending_full(pending_full), .o_drop_count(drop_count),
    .o_state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W+1:0] head;
    check("tvalid", 64'(tvalid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      check("tdata", 64'(tdata), 64'(head[W-1:0]));
      check("tlast", 64'(tlast), 64'(head[W]));
      check("tside", 64'(tside), 64'(head[W+1]));
    end
    check("pending_full", 64'(pending_full), 64'(exp_q.size() > PW));
    check("drop_count", 64'(drop_count), 64'(drops_exp));
  endtask

  task automatic set_pair(input logic [W-1:0] base_b, input logic [W-1:0] base_s);
    for (int n = 0; n < N; n++) begin
      buy_w[n]  = base_b + W'(n);
      sell_w[n] = base_s + W'(n);
    end
  endtask

  task automatic set_rand_pair();
    for (int n = 0; n < N; n++) begin
      buy_w[n]  = $urandom;
      sell_w[n] = $urandom;
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model at the edge,
  // then scramble the message inputs so only i_valid-cycle data can matter.
  task automatic step(input logic v, input logic r);
    @(negedge clk);
    check_outputs();
    valid  = v;
    tready = r;
    @(posedge clk);
    if (exp_q.size() > 0 && tready) void'(exp_q.pop_front());
    if (valid) begin
      if (exp_q.size() <= PW) begin
        for (int n = 0; n < N; n++) exp_q.push_back({1'b0, 1'(n == N - 1), buy_w[n]});
        for (int n = 0; n < N; n++) exp_q.push_back({1'b1, 1'(n == N - 1), sell_w[n]});
      end else if (drops_exp < 65535) begin
        drops_exp++;
      end
    end
    #1;
    set_rand_pair();
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1);
  endtask

  // Advance with i_tready=1 until the model holds 'depth' words; an expired
  // bound is reported as a failed comparison.
  task automatic run_to_depth(input int depth);
    int k;
    k = 0;
    while (exp_q.size() != depth && k < 60) begin
      step(1'b0, 1'b1);
      k++;
    end
    check("reach_depth", 64'(exp_q.size()), 64'(depth));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; drops_exp = 0;
    rst = 1'b1; valid = 1'b0; tready = 1'b0;
    set_rand_pair();
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tside", 64'(tside), 64'd0);
    check("rst_pending", 64'(pending_full), 64'd0);
    check("rst_drops", 64'(drop_count), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic pair, continuous ready.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b1);
    drain(22);

    // Backpressure 1,0,0 pattern.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, (i % 3) == 0);
    drain(4);

    // Pending pair B three cycles after A.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b1);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    set_pair(32'h300, 32'h400); step(1'b1, 1'b1);
    drain(40);

    // Drop: A, B, C back to back with ready low.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b0);
    set_pair(32'h300, 32'h400); step(1'b1, 1'b0);
    set_pair(32'h500, 32'h600); step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    drain(40);

    // New pair coincides with pair-done, pending empty.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b1);
    run_to_depth(1);
    set_pair(32'h300, 32'h400); step(1'b1, 1'b1);
    drain(22);

    // New pair coincides with pair-done, pending full.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b1);
    set_pair(32'h300, 32'h400); step(1'b1, 1'b1);
    run_to_depth(PW + 1);
    set_pair(32'h500, 32'h600); step(1'b1, 1'b1);
    drain(60);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      set_rand_pair();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    drain(40);

    // Saturate the drop counter.
    set_rand_pair(); step(1'b1, 1'b0);
    set_rand_pair(); step(1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b0);
    check("drop_saturated", 64'(drop_count), 64'hFFFF);
    drain(40);

    // Reset during buy word 4 with a pending pair held.
    set_pair(32'h100, 32'h200); step(1'b1, 1'b1);
    set_pair(32'h300, 32'h400); step(1'b1, 1'b1);
    run_to_depth(PW + PW - 4);
    @(negedge clk);
    check("pre_rst_tdata", 64'(tdata), 64'h104);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_pending", 64'(pending_full), 64'd0);
    check("mid_rst_drops", 64'(drop_count), 64'd0);
    exp_q.delete();
    drops_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/order_tx_serializer.md
Name: order_tx_serializer

Overview:
- Sits directly downstream of the trading top level.
- Consumes the paired buy/sell 9-register quote messages, which are presented in parallel with a one-cycle valid.
- Serialises them onto a single 32-bit word stream with valid/ready handshake toward the network/DMA egress.
- Buffers one in-flight pair plus one pending pair. Further pairs arriving while both slots are full are dropped and counted.

Parameters:
REG_WIDTH, 32, width of each message register and of the output word
NUM_REGS, 9, registers per message (buy and sell each)
DROP_CNT_WIDTH, 16, width of saturating drop counter

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset  input  1  asynchronous active-high reset
i_valid  input  1  single-cycle strobe: i_reg_*_b and i_reg_*_s valid this cycle
i_reg_0_b..i_reg_8_b  input  REG_WIDTH each  buy message words 0..8
i_reg_0_s..i_reg_8_s  input  REG_WIDTH each  sell message words 0..8
o_tdata  output  REG_WIDTH  current output word
o_tvalid  output  1  o_tdata valid
i_tready  input  1  downstream accepts word when o_tvalid & i_tready
o_tlast  output  1  high on word 8 of each message
o_tside  output  1  0 = buy message word, 1 = sell message word
o_pending_full  output  1  pending slot occupied; the next i_valid is dropped unless the active pair completes that cycle
o_drop_count  output  DROP_CNT_WIDTH  pairs dropped, saturating

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-transfer included):
  - State is IDLE; active and pending slots are empty.
  - o_tvalid=0, o_tlast=0, o_tside=0, o_tdata=0, o_pending_full=0, o_drop_count=0.
  - A partially sent message is abandoned and no tail is emitted.
- Storage:
  - Active slot holds 2×NUM_REGS words.
  - Pending slot holds 2×NUM_REGS words.
  - Word index counter runs 0..NUM_REGS-1.
- States:
  - IDLE: o_tvalid=0.
  - SEND_BUY: o_tvalid=1, o_tside=0, o_tdata = active buy word[idx].
  - SEND_SELL: o_tvalid=1, o_tside=1, o_tdata = active sell word[idx].
- o_tlast = (idx == NUM_REGS-1) in either SEND state.
- Transitions (a transfer is o_tvalid & i_tready):
  - IDLE, i_valid: load active, idx=0, go to SEND_BUY. Latency: o_tvalid rises the cycle after i_valid.
  - SEND_BUY, transfer, idx<8: idx+1.
  - SEND_BUY, transfer, idx=8: idx=0, go to SEND_SELL.
  - SEND_SELL, transfer, idx<8: idx+1.
  - SEND_SELL, transfer, idx=8 ("pair done"): if a pending pair exists, move it to active, idx=0, go to SEND_BUY; else go to IDLE.
- AXI-style stability: while o_tvalid=1 and i_tready=0, o_tdata/o_tlast/o_tside hold. o_tvalid never drops without a transfer, except on reset.
- i_valid while not in IDLE:
  - Pending empty: capture into pending; o_pending_full=1 the next cycle.
  - Pending full and not pair done this cycle: drop the pair; o_drop_count+1, saturating at all-ones.
- Simultaneous i_valid and pair done:
  - Pending full: pending moves to active and the new pair loads into pending. No drop.
  - Pending empty: the new pair loads directly into active and SEND_BUY starts next cycle with no bubble.
- Throughput: one word per cycle with i_tready=1. A pair occupies 18 cycles; back-to-back pairs have no idle cycle.
- Input data is sampled only on the i_valid cycle. Later changes on i_reg_* do not affect buffered words.
- o_pending_full is a registered copy of pending occupancy.

Test Plan:
- Basic: reset, then i_valid with buy word n = 0x100+n and sell word n = 0x200+n, i_tready=1.
  - Expect o_tvalid from the next cycle for exactly 18 cycles.
  - o_tdata runs 0x100..0x108 then 0x200..0x208.
  - o_tlast high on 0x108 and 0x208; o_tside 0 then 1.
- Backpressure: same stimulus, i_tready toggling 1,0,0,1,...
  - Every word appears once, in order.
  - o_tdata/o_tlast/o_tside hold while i_tready=0.
  - 18 transfers total.
- Pending: send pair A (0x1xx/0x2xx), then pair B (0x3xx/0x4xx) 3 cycles later.
  - o_pending_full=1 from the cycle after B's i_valid until pair A's final sell word is accepted.
  - B's words follow A with no idle cycle; 36 transfers total.
- Drop: pairs A, B, C strobed on consecutive cycles with i_tready=0.
  - C is dropped: o_drop_count=1.
  - After releasing i_tready, output is A then B only.
  - Drop counter saturates at 0xFFFF after 65536+ drops.
- Simultaneous: i_valid for pair B coincides with the transfer of pair A's sell word 8, with pending empty.
  - B's buy word 0 is presented the next cycle; no drop.
  - Repeat with pending full: the pending pair is sent next and B becomes pending.
- Reset mid-operation: assert i_reset during buy word 4 of a pair while a pending pair exists.
  - o_tvalid=0 and o_pending_full=0 immediately; o_drop_count=0.
  - After reset release, no residual words are emitted.
